// File: rtl/nano_prog_if.sv
// Program-memory bus between the serial programming port and the memory.
// master = programming port, slave = program memory.
interface nano_prog_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/nano_prog_port.sv
// Serial programming port: 16-bit host frames drive program-memory
// writes/reads and the CPU run/halt level.
module nano_prog_port #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ser_sclk,
    input  logic        ser_cs_n,
    input  logic        ser_mosi,
    output logic        ser_miso,
    nano_prog_if.master mem,
    output logic        cpu_run,
    output logic        busy,
    output logic        frame_err
);
    localparam int OP_W = 8 - ADDR_W;
    localparam logic [OP_W-1:0] OP_WRITE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_READ  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_RUN   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4);

    typedef enum logic [2:0] {
        IDLE, CMD, FETCH, DATA, EXEC, DRAIN
    } state_e;

    state_e state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES:0]   arm_q, arm_d;
    logic                   sclk_d1_q, sclk_d1_d;
    logic                   cs_d1_q, cs_d1_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_in_q, shift_in_d;
    logic [7:0]             shift_out_q, shift_out_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic                   fetch_wait_q, fetch_wait_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   run_q, run_d;
    logic                   err_q, err_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic abort;
    logic [7:0] cmd_byte;
    logic [OP_W-1:0] cmd_op;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;
    assign cs_rise   = cs_s & ~cs_d1_q;
    assign cs_fall   = ~cs_s & cs_d1_q;
    assign cmd_byte  = {shift_in_q, mosi_s};
    assign cmd_op    = cmd_byte[7:ADDR_W];
    assign abort     = cs_rise &&
                       (state_q == CMD || state_q == FETCH ||
                        state_q == DATA);

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], ser_sclk};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], ser_cs_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], ser_mosi};
        arm_d        = {arm_q[SYNC_STAGES-1:0], 1'b1};
        sclk_d1_d    = sclk_s;
        cs_d1_d      = cs_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        op_d         = op_q;
        fetch_wait_d = fetch_wait_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        run_d        = run_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        err_d        = 1'b0;

        // cs_n rising wins over a same-cycle sclk edge
        if (abort) begin
            err_d        = 1'b1;
            state_d      = IDLE;
            bit_cnt_d    = '0;
            shift_out_d  = '0;
            fetch_wait_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // arm gate: a low cs_n seen while the
                    // synchronizer flushes after reset is no edge
                    if (cs_fall && arm_q[SYNC_STAGES]) begin
                        state_d     = CMD;
                        bit_cnt_d   = '0;
                        shift_in_d  = '0;
                        shift_out_d = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_in_d = cmd_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            op_d = cmd_op;
                            unique case (1'b1)
                                (cmd_op == OP_READ): begin
                                    addr_d       = cmd_byte[ADDR_W-1:0];
                                    re_d         = 1'b1;
                                    fetch_wait_d = 1'b1;
                                    state_d      = FETCH;
                                end
                                (cmd_op == OP_WRITE): begin
                                    addr_d  = cmd_byte[ADDR_W-1:0];
                                    state_d = DATA;
                                end
                                (cmd_op == OP_RUN),
                                (cmd_op == OP_HALT): begin
                                    state_d = DATA;
                                end
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = DRAIN;
                                end
                            endcase
                        end
                    end
                end
                FETCH: begin
                    // first cycle: memory samples mem_re
                    if (fetch_wait_q) begin
                        fetch_wait_d = 1'b0;
                    end else begin
                        shift_out_d = mem.mem_rdata;
                        state_d     = DATA;
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        shift_in_d = cmd_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_d     = EXEC;
                            shift_out_d = '0;
                            if (op_q == OP_WRITE) begin
                                we_d    = 1'b1;
                                wdata_d = cmd_byte;
                            end
                            if (op_q == OP_RUN)  run_d = 1'b1;
                            if (op_q == OP_HALT) run_d = 1'b0;
                        end
                    end else if (sclk_fall && bit_cnt_q >= 5'd9) begin
                        // the fall after bit 8 must not drop the MSB
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end
                end
                EXEC: begin
                    state_d = cs_rise ? IDLE : DRAIN;
                end
                DRAIN: begin
                    if (cs_rise) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            arm_q        <= '0;
            sclk_d1_q    <= 1'b0;
            cs_d1_q      <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_in_q   <= '0;
            shift_out_q  <= '0;
            op_q         <= '0;
            fetch_wait_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            run_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            arm_q        <= arm_d;
            sclk_d1_q    <= sclk_d1_d;
            cs_d1_q      <= cs_d1_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            op_q         <= op_d;
            fetch_wait_q <= fetch_wait_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            re_q         <= re_d;
            run_q        <= run_d;
            err_q        <= err_d;
        end
    end

    assign ser_miso      = shift_out_q[7];
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_re    = re_q;
    assign cpu_run       = run_q;
    assign busy          = ~cs_s;
    assign frame_err     = err_q;
endmodule

// File: tb/tb_nano_prog_port.sv
// Directed bench for nano_prog_port: host frames bit-banged at clk/16,
// memory model with one-cycle read latency, strobe monitors.
module tb_nano_prog_port;
    logic clk = 1'b0;
    logic rst_n;
    logic ser_sclk, ser_cs_n, ser_mosi, ser_miso;
    logic cpu_run, busy, frame_err;

    int checks = 0;
    int errors = 0;

    int we_cnt = 0, re_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [3:0] we_addr = '0, re_addr = '0;
    logic [7:0] we_data = '0;
    logic [7:0] mem_arr [16];

    nano_prog_if #(.ADDR_W(4)) mem_if ();

    nano_prog_port #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_sclk  (ser_sclk),
        .ser_cs_n  (ser_cs_n),
        .ser_mosi  (ser_mosi),
        .ser_miso  (ser_miso),
        .mem       (mem_if),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_if.mem_re) mem_if.mem_rdata <= mem_arr[mem_if.mem_addr];
    end

    always @(negedge clk) begin
        if (mem_if.mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_if.mem_addr;
            we_data = mem_if.mem_wdata;
        end
        if (mem_if.mem_re) begin
            re_cnt  = re_cnt + 1;
            re_addr = mem_if.mem_addr;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (mem_if.mem_we && mem_if.mem_re) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        ser_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        ser_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic m);
        ser_mosi = b;
        repeat (8) @(negedge clk);
        ser_sclk = 1'b1;
        m = ser_miso;
        repeat (8) @(negedge clk);
        ser_sclk = 1'b0;
    endtask

    task automatic frame(input logic [15:0] w, input int n,
                         output logic [15:0] mi);
        logic b;
        mi = '0;
        cs_low();
        for (int i = 0; i < n; i++) begin
            send_bit(w[15-i], b);
            mi[15-i] = b;
        end
        cs_high();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_miso"},  32'(ser_miso), 0);
        chk({tag, "_addr"},  32'(mem_if.mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_if.mem_wdata), 0);
        chk({tag, "_we"},    32'(mem_if.mem_we), 0);
        chk({tag, "_re"},    32'(mem_if.mem_re), 0);
        chk({tag, "_run"},   32'(cpu_run), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_err"},   32'(frame_err), 0);
    endtask

    initial begin
        logic [15:0] mi;
        logic b;
        int we0, re0, err0;

        for (int i = 0; i < 16; i++) mem_arr[i] = 8'(i * 17);
        mem_arr[9] = 8'h3C;
        rst_n = 1'b0;
        ser_sclk = 1'b0;
        ser_cs_n = 1'b1;
        ser_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // WRITE addr 5 data A7
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        cs_low();
        chk("busy_in_frame", 32'(busy), 1);
        for (int i = 0; i < 16; i++) send_bit(1'(16'h15A7 >> (15 - i)), b);
        cs_high();
        chk("wr_we_count", we_cnt - we0, 1);
        chk("wr_addr", 32'(we_addr), 5);
        chk("wr_data", 32'(we_data), 32'hA7);
        chk("wr_no_re", re_cnt - re0, 0);
        chk("wr_no_err", err_cnt - err0, 0);
        chk("wr_busy_after", 32'(busy), 0);

        // READ addr 9
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        frame(16'h2900, 16, mi);
        chk("rd_re_count", re_cnt - re0, 1);
        chk("rd_addr", 32'(re_addr), 9);
        chk("rd_miso_bits", 32'(mi), 32'h003C);
        chk("rd_no_we", we_cnt - we0, 0);
        chk("rd_no_err", err_cnt - err0, 0);
        chk("miso_idle", 32'(ser_miso), 0);

        // RUN then HALT then RUN
        we0 = we_cnt;
        frame(16'h3000, 16, mi);
        chk("run_set", 32'(cpu_run), 1);
        frame(16'h4000, 16, mi);
        chk("halt_clr", 32'(cpu_run), 0);
        frame(16'h3000, 16, mi);
        chk("run_again", 32'(cpu_run), 1);
        chk("runhalt_no_we", we_cnt - we0, 0);

        // aborted WRITE after 11 bits
        we0 = we_cnt; err0 = err_cnt;
        frame(16'h1255, 11, mi);
        chk("abort_no_we", we_cnt - we0, 0);
        chk("abort_err", err_cnt - err0, 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_run_kept", 32'(cpu_run), 1);

        // illegal opcode 7
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        cs_low();
        for (int i = 0; i < 8; i++) send_bit(1'(16'h7F00 >> (15 - i)), b);
        repeat (4) @(negedge clk);
        chk("illegal_err_at_bit8", err_cnt - err0, 1);
        for (int i = 8; i < 16; i++) send_bit(1'(16'h7F00 >> (15 - i)), b);
        cs_high();
        chk("illegal_err_once", err_cnt - err0, 1);
        chk("illegal_no_we", we_cnt - we0, 0);
        chk("illegal_no_re", re_cnt - re0, 0);
        chk("illegal_run_kept", 32'(cpu_run), 1);

        // cs_n rises together with the 16th sclk rise: bit dropped
        we0 = we_cnt; err0 = err_cnt;
        cs_low();
        for (int i = 0; i < 15; i++) send_bit(1'(16'h1C33 >> (15 - i)), b);
        ser_mosi = 1'b1;
        repeat (8) @(negedge clk);
        ser_sclk = 1'b1;
        ser_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        ser_sclk = 1'b0;
        repeat (10) @(negedge clk);
        chk("tie_no_we", we_cnt - we0, 0);
        chk("tie_err", err_cnt - err0, 1);

        // reset during bit 12 of a WRITE
        we0 = we_cnt; err0 = err_cnt;
        cs_low();
        for (int i = 0; i < 11; i++) send_bit(1'(16'h1655 >> (15 - i)), b);
        ser_mosi = 1'b0;
        repeat (8) @(negedge clk);
        ser_sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ser_sclk = 1'b0;
        repeat (8) @(negedge clk);
        ser_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_we", we_cnt - we0, 0);
        chk("midrst_no_err", err_cnt - err0, 0);
        chk("midrst_run_off", 32'(cpu_run), 0);

        we0 = we_cnt;
        frame(16'h1B55, 16, mi);
        chk("post_rst_we", we_cnt - we0, 1);
        chk("post_rst_addr", 32'(we_addr), 32'hB);
        chk("post_rst_data", 32'(we_data), 32'h55);
        chk("never_we_and_re", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
